// File: rtl/one_by_n_seq.sv
// one_by_n_seq: sequential restoring divider producing the Q1.16 reciprocal
// of an 8-bit count n, one quotient bit per clock, with a start/done handshake.
// A zero divisor saturates to 0x1FFFF and raises div_by_zero.
// Optional build macro ONE_BY_N_ROUND_EN: bias the dividend by floor(n/2)
// for round-to-nearest; undefined gives truncation matching the OneByN lookup.
module one_by_n_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  n,
   output logic        busy,
   output logic        done,
   output logic [16:0] one_by_n,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [4:0]  LastStep  = 5'd16;
   localparam logic [16:0] OneQ16    = 17'h10000;
   localparam logic [16:0] Saturated = 17'h1FFFF;

   state_t      state;
   state_t      nextState;

   logic [7:0]  divisorReg;
   logic [16:0] dividendReg;
   logic [7:0]  remReg;
   logic [15:0] quotReg;
   logic [4:0]  bitCnt;

   logic        startAccept;
   logic        divisorZero;
   logic        lastStep;
   logic [8:0]  remShift;
   logic        remGeq;
   logic [7:0]  remNext;
   logic [16:0] quotNext;
   logic [16:0] dividendInit;

   assign startAccept = start && ((state == IDLE) || (state == DONE));
   assign divisorZero = (divisorReg == 8'd0);
   assign lastStep    = (bitCnt == LastStep);

   // One restoring step: shift the next dividend bit into the remainder and
   // subtract the divisor when it fits. The kept remainder is always below the
   // divisor, so eight bits hold it; the 8-bit subtraction is exact whenever
   // remGeq is set because the true difference is below 256.
   assign remShift = {remReg, dividendReg[16]};
   assign remGeq   = (remShift >= {1'b0, divisorReg});
   assign remNext  = remGeq ? (remShift[7:0] - divisorReg) : remShift[7:0];
   assign quotNext = {quotReg, remGeq};

`ifdef ONE_BY_N_ROUND_EN
   assign dividendInit = OneQ16 + {10'd0, n[7:1]};
`else
   assign dividendInit = OneQ16;
`endif

   assign busy = (state == CALC);
   assign done = (state == DONE);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A zero divisor still spends one CALC cycle so its done
   // pulse lands one edge after acceptance rather than in the same cycle.
   always_comb begin
      // NOTE: default first so every path assigns nextState and no latch forms.
      nextState = state;
      unique case (state)
         IDLE: begin
            if (startAccept) nextState = CALC;
         end
         CALC: begin
            if (divisorZero || lastStep) nextState = DONE;
         end
         DONE: begin
            nextState = startAccept ? CALC : IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Datapath: capture operands on an accepted start, iterate in CALC, and
   // register the result (held until the next finished computation).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divisorReg  <= '0;
         dividendReg <= '0;
         remReg      <= '0;
         quotReg     <= '0;
         bitCnt      <= '0;
         one_by_n    <= '0;
         div_by_zero <= 1'b0;
      end else if (startAccept) begin
         divisorReg  <= n;
         dividendReg <= dividendInit;
         remReg      <= '0;
         quotReg     <= '0;
         bitCnt      <= '0;
      end else if (state == CALC) begin
         if (divisorZero) begin
            one_by_n    <= Saturated;
            div_by_zero <= 1'b1;
         end else begin
            remReg      <= remNext;
            dividendReg <= {dividendReg[15:0], 1'b0};
            quotReg     <= quotNext[15:0];
            bitCnt      <= bitCnt + 5'd1;
            if (lastStep) begin
               one_by_n    <= quotNext;
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule
